reorder_buffer: RTL and testbench

- Circular in-order retirement buffer for the out-of-order core.
- Decode/dispatch allocates entries; the CDB marks them complete.
- The head entry retires onto the commit bus, which drives register-file writeback, register-status release and misprediction flush.
- It is the producer side of the commit interface that decode consumes. It also generates the full-stall signal and the destination ROB tag.

---
 rtl/core_pkg.sv | 29 ++
 rtl/rob_pointer.sv | 39 +++
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and sizing for the reorder buffer slice: entry storage layout and commit bundle.
// Optional operand-read ports in the top are enabled by ROB_OPERAND_READ_EN.
package core_pkg;

  localparam int unsigned WIDTH_P = 31;
  localparam int unsigned REG_P   = 4;
  localparam int unsigned ROB_P   = 2;
  localparam int unsigned DEPTH   = 2 ** (ROB_P + 1);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             regWrite;
    logic [REG_P:0]   destReg;
    logic             branch;
    logic             mispredict;
    logic [WIDTH_P:0] result;
    logic [WIDTH_P:0] target;
    logic [WIDTH_P:0] snap;
  } rob_entry_t;

  typedef struct packed {
    logic             regWrite;
    logic [REG_P:0]   destReg;
    logic [ROB_P:0]   robTag;
    logic [WIDTH_P:0] result;
  } commit_t;

endpackage

// File: rtl/rob_pointer.sv
// Head/tail pointers with an extra wrap bit plus an occupancy count; full when count hits depth.
module rob_pointer #(
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DEPTH_N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [TAG_W-1:0] o_head_idx,
  output logic [TAG_W-1:0] o_tail_idx,
  output logic             o_full
);

  logic [TAG_W:0] r_head;
  logic [TAG_W:0] r_tail;
  logic [TAG_W:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      if (i_push && !i_pop)
        r_count <= r_count + 1'b1;
      else if (i_pop && !i_push)
        r_count <= r_count - 1'b1;
    end
  end

  assign o_head_idx = r_head[TAG_W-1:0];
  assign o_tail_idx = r_tail[TAG_W-1:0];
  assign o_full     = (r_count == (TAG_W + 1)'(DEPTH_N));

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: dispatch allocates, CDB completes, head retires onto the commit bus.
// Define ROB_OPERAND_READ_EN to add combinational operand-read ports with CDB forwarding.
module reorder_buffer
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_P,
  parameter int unsigned REG   = REG_P,
  parameter int unsigned ROB   = ROB_P
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           allocReq,
  input  logic           allocRegWrite,
  input  logic [REG:0]   allocDestReg,
  input  logic           allocBranch,
  input  logic [WIDTH:0] allocStatusSnap,
  input  logic           cdbValid,
  input  logic [ROB:0]   cdbROB,
  input  logic [WIDTH:0] cdbResult,
  input  logic           cdbMispredict,
  input  logic [WIDTH:0] cdbTarget,
  output logic           fullRob,
  output logic [ROB:0]   destROB,
  output logic           commitValid,
  output logic           commitRegWrite,
  output logic [REG:0]   commitDestReg,
  output logic [ROB:0]   commitROB,
  output logic [WIDTH:0] commitResult,
  output logic           flush,
  output logic [WIDTH:0] redirectPC,
  output logic [WIDTH:0] regStatusRestore
`ifdef ROB_OPERAND_READ_EN
  ,
  input  logic [ROB:0]   rdTag1,
  input  logic [ROB:0]   rdTag2,
  output logic           rdReady1,
  output logic           rdReady2,
  output logic [WIDTH:0] rdValue1,
  output logic [WIDTH:0] rdValue2
`endif
);

  localparam int unsigned DEPTH_L = 2 ** (ROB + 1);

  rob_entry_t     r_entries [DEPTH_L];
  commit_t        r_commit;
  logic           r_commitValid;
  logic           r_flush;
  logic [WIDTH:0] r_redirectPC;
  logic [WIDTH:0] r_regStatusRestore;

  logic [ROB:0]   w_head_idx;
  logic [ROB:0]   w_tail_idx;
  logic           w_full;
  rob_entry_t     w_head_entry;
  logic           w_alloc;
  logic           w_complete;
  logic           w_retire;
  logic           w_mispredict_retire;

  rob_pointer #(
    .TAG_W   (ROB + 1),
    .DEPTH_N (DEPTH_L)
  ) u_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_alloc),
    .i_pop      (w_retire),
    .i_clear    (w_mispredict_retire),
    .o_head_idx (w_head_idx),
    .o_tail_idx (w_tail_idx),
    .o_full     (w_full)
  );

  assign w_head_entry        = r_entries[w_head_idx];
  // The registered flush blocks allocation during the squash cycle.
  assign w_alloc             = allocReq && !w_full && !r_flush;
  assign w_complete          = cdbValid && r_entries[cdbROB].valid;
  assign w_retire            = w_head_entry.valid && w_head_entry.done;
  assign w_mispredict_retire = w_retire && w_head_entry.mispredict;

  always_ff @(posedge clk) begin
    if (reset || w_mispredict_retire) begin
      r_entries <= '{default: '0};
    end else begin
      if (w_alloc) begin
        r_entries[w_tail_idx] <= '{valid:      1'b1,
                                   done:       1'b0,
                                   regWrite:   allocRegWrite,
                                   destReg:    allocDestReg,
                                   branch:     allocBranch,
                                   mispredict: 1'b0,
                                   result:     '0,
                                   target:     '0,
                                   snap:       allocStatusSnap};
      end
      if (w_complete) begin
        r_entries[cdbROB].result <= cdbResult;
        r_entries[cdbROB].done   <= 1'b1;
        if (r_entries[cdbROB].branch) begin
          r_entries[cdbROB].mispredict <= cdbMispredict;
          r_entries[cdbROB].target     <= cdbTarget;
        end
      end
      if (w_retire) r_entries[w_head_idx].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit           <= '0;
      r_commitValid      <= 1'b0;
      r_flush            <= 1'b0;
      r_redirectPC       <= '0;
      r_regStatusRestore <= '0;
    end else begin
      r_commitValid      <= w_retire;
      r_flush            <= w_mispredict_retire;
      r_redirectPC       <= w_mispredict_retire ? w_head_entry.target : '0;
      r_regStatusRestore <= w_mispredict_retire ? w_head_entry.snap   : '0;
      if (w_retire) begin
        r_commit <= '{regWrite: w_head_entry.regWrite,
                      destReg:  w_head_entry.destReg,
                      robTag:   w_head_idx,
                      result:   w_head_entry.result};
      end
    end
  end

  assign fullRob          = w_full;
  assign destROB          = w_tail_idx;
  assign commitValid      = r_commitValid;
  assign commitRegWrite   = r_commit.regWrite;
  assign commitDestReg    = r_commit.destReg;
  assign commitROB        = r_commit.robTag;
  assign commitResult     = r_commit.result;
  assign flush            = r_flush;
  assign redirectPC       = r_redirectPC;
  assign regStatusRestore = r_regStatusRestore;

`ifdef ROB_OPERAND_READ_EN
  always_comb begin
    rdReady1 = 1'b0;
    rdValue1 = '0;
    rdReady2 = 1'b0;
    rdValue2 = '0;
    if (cdbValid && cdbROB == rdTag1) begin
      rdReady1 = 1'b1;
      rdValue1 = cdbResult;
    end else if (r_entries[rdTag1].valid && r_entries[rdTag1].done) begin
      rdReady1 = 1'b1;
      rdValue1 = r_entries[rdTag1].result;
    end
    if (cdbValid && cdbROB == rdTag2) begin
      rdReady2 = 1'b1;
      rdValue2 = cdbResult;
    end else if (r_entries[rdTag2].valid && r_entries[rdTag2].done) begin
      rdReady2 = 1'b1;
      rdValue2 = r_entries[rdTag2].result;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based in-order retirement model checked every cycle.
module tb_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        allocReq;
  logic        allocRegWrite;
  logic [4:0]  allocDestReg;
  logic        allocBranch;
  logic [31:0] allocStatusSnap;
  logic        cdbValid;
  logic [2:0]  cdbROB;
  logic [31:0] cdbResult;
  logic        cdbMispredict;
  logic [31:0] cdbTarget;
  logic        fullRob;
  logic [2:0]  destROB;
  logic        commitValid;
  logic        commitRegWrite;
  logic [4:0]  commitDestReg;
  logic [2:0]  commitROB;
  logic [31:0] commitResult;
  logic        flush;
  logic [31:0] redirectPC;
  logic [31:0] regStatusRestore;

  reorder_buffer #(.WIDTH(31), .REG(4), .ROB(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .allocReq         (allocReq),
    .allocRegWrite    (allocRegWrite),
    .allocDestReg     (allocDestReg),
    .allocBranch      (allocBranch),
    .allocStatusSnap  (allocStatusSnap),
    .cdbValid         (cdbValid),
    .cdbROB           (cdbROB),
    .cdbResult        (cdbResult),
    .cdbMispredict    (cdbMispredict),
    .cdbTarget        (cdbTarget),
    .fullRob          (fullRob),
    .destROB          (destROB),
    .commitValid      (commitValid),
    .commitRegWrite   (commitRegWrite),
    .commitDestReg    (commitDestReg),
    .commitROB        (commitROB),
    .commitResult     (commitResult),
    .flush            (flush),
    .redirectPC       (redirectPC),
    .regStatusRestore (regStatusRestore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: program-order queue of in-flight instructions.
  typedef struct {
    int          tag;
    bit          rw;
    bit [4:0]    rd;
    bit          br;
    bit [31:0]   snap;
    bit          done;
    bit          mp;
    bit [31:0]   res;
    bit [31:0]   tgt;
  } ent_t;

  ent_t        q[$];
  ent_t        h;
  ent_t        ne;
  int          mtail = 0;
  bit          started = 0;
  bit          m_ret, m_fl, m_alc;
  bit          exp_cv, exp_flush, exp_rw;
  bit [4:0]    exp_rd;
  bit [2:0]    exp_rob;
  bit [31:0]   exp_res, exp_redirect, exp_restore;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      q.delete();
      mtail = 0;
      exp_cv = 0; exp_flush = 0; exp_rw = 0; exp_rd = '0; exp_rob = '0;
      exp_res = '0; exp_redirect = '0; exp_restore = '0;
    end else begin
      m_ret = (q.size() > 0) && q[0].done;
      m_alc = allocReq && (q.size() < 8) && !exp_flush;
      if (m_ret) h = q[0];
      if (cdbValid) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(cdbROB)) begin
            q[i].done = 1;
            q[i].res  = cdbResult;
            if (q[i].br) begin
              q[i].mp  = cdbMispredict;
              q[i].tgt = cdbTarget;
            end
          end
        end
      end
      m_fl         = m_ret && h.mp;
      exp_cv       = m_ret;
      exp_flush    = m_fl;
      exp_redirect = m_fl ? h.tgt  : 32'h0;
      exp_restore  = m_fl ? h.snap : 32'h0;
      if (m_ret) begin
        exp_rw  = h.rw;
        exp_rd  = h.rd;
        exp_rob = 3'(h.tag);
        exp_res = h.res;
        void'(q.pop_front());
      end
      if (m_fl) begin
        q.delete();
        mtail = 0;
      end else if (m_alc) begin
        ne = '{tag: mtail, rw: allocRegWrite, rd: allocDestReg, br: allocBranch,
               snap: allocStatusSnap, done: 0, mp: 0, res: 0, tgt: 0};
        q.push_back(ne);
        mtail = (mtail + 1) % 8;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_full",     32'(fullRob),          32'(q.size() == 8));
      chk("model_destROB",  32'(destROB),          32'(mtail));
      chk("model_cv",       32'(commitValid),      32'(exp_cv));
      chk("model_flush",    32'(flush),            32'(exp_flush));
      chk("model_redirect", redirectPC,            exp_redirect);
      chk("model_restore",  regStatusRestore,      exp_restore);
      if (exp_cv) begin
        chk("model_rw",  32'(commitRegWrite), 32'(exp_rw));
        chk("model_rd",  32'(commitDestReg),  32'(exp_rd));
        chk("model_rob", 32'(commitROB),      32'(exp_rob));
        chk("model_res", commitResult,        exp_res);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic alloc1(input logic [4:0] rd, input logic rw, input logic br, input logic [31:0] snap);
    allocReq = 1'b1; allocDestReg = rd; allocRegWrite = rw; allocBranch = br; allocStatusSnap = snap;
    step();
    allocReq = 1'b0; allocBranch = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] res, input logic mp, input logic [31:0] tgt);
    cdbValid = 1'b1; cdbROB = tag; cdbResult = res; cdbMispredict = mp; cdbTarget = tgt;
    step();
    cdbValid = 1'b0; cdbMispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] t;

  initial begin
    reset = 1'b1; allocReq = 1'b0; allocRegWrite = 1'b0; allocDestReg = '0; allocBranch = 1'b0;
    allocStatusSnap = '0; cdbValid = 1'b0; cdbROB = '0; cdbResult = '0; cdbMispredict = 1'b0;
    cdbTarget = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_full", 32'(fullRob), 32'h0);
    chk("rst_dest", 32'(destROB), 32'h0);
    chk("rst_cv",   32'(commitValid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);

    // Fill all 8 slots; tag 2 is a branch.
    for (int i = 0; i < 8; i++) begin
      chk("fill_dest", 32'(destROB), 32'(i));
      alloc1(5'(i + 1), (i != 2), (i == 2), 32'hF0);
    end
    chk("fill_full", 32'(fullRob), 32'h1);
    chk("fill_wrap_dest", 32'(destROB), 32'h0);
    alloc1(5'd9, 1'b1, 1'b0, 32'h0);
    chk("ninth_ignored_dest", 32'(destROB), 32'h0);
    chk("ninth_full", 32'(fullRob), 32'h1);

    // Out-of-order completion, in-order retire.
    cdb(3'd1, 32'hAA, 1'b0, 32'h0);
    chk("ooo_no_commit", 32'(commitValid), 32'h0);
    cdb(3'd0, 32'h55, 1'b0, 32'h0);
    chk("latency_no_same_cycle", 32'(commitValid), 32'h0);
    step();
    chk("c0_valid", 32'(commitValid), 32'h1);
    chk("c0_rd",    32'(commitDestReg), 32'h1);
    chk("c0_res",   commitResult, 32'h55);
    chk("c0_rob",   32'(commitROB), 32'h0);
    step();
    chk("c1_valid", 32'(commitValid), 32'h1);
    chk("c1_rd",    32'(commitDestReg), 32'h2);
    chk("c1_res",   commitResult, 32'hAA);
    chk("c1_rob",   32'(commitROB), 32'h1);

    // Mispredicted branch at tag 2.
    cdb(3'd2, 32'h0, 1'b1, 32'h100);
    chk("br_pre_cv", 32'(commitValid), 32'h0);
    step();
    chk("br_flush",    32'(flush), 32'h1);
    chk("br_redirect", redirectPC, 32'h100);
    chk("br_restore",  regStatusRestore, 32'hF0);
    chk("br_rob",      32'(commitROB), 32'h2);
    chk("br_full",     32'(fullRob), 32'h0);
    allocReq = 1'b1; allocDestReg = 5'd21; allocRegWrite = 1'b1; allocStatusSnap = 32'h0;
    step();
    chk("flush_drop", 32'(flush), 32'h0);
    chk("flush_redirect_clr", redirectPC, 32'h0);
    chk("flush_alloc_ignored", 32'(destROB), 32'h0);
    step();
    allocReq = 1'b0;
    chk("post_flush_alloc", 32'(destROB), 32'h1);

    // Full ROB with head completing while allocReq is held.
    for (int i = 0; i < 7; i++) alloc1(5'(10 + i), 1'b1, 1'b0, 32'h0);
    chk("full2", 32'(fullRob), 32'h1);
    cdb(3'd0, 32'h33, 1'b0, 32'h0);
    chk("full2_no_cv", 32'(commitValid), 32'h0);
    allocReq = 1'b1; allocDestReg = 5'd22;
    step();
    chk("full_retire_cv",  32'(commitValid), 32'h1);
    chk("full_retire_rob", 32'(commitROB), 32'h0);
    chk("full_retire_res", commitResult, 32'h33);
    chk("full_retire_dest", 32'(destROB), 32'h0);
    step();
    allocReq = 1'b0;
    chk("full_realloc_full", 32'(fullRob), 32'h1);
    chk("full_realloc_dest", 32'(destROB), 32'h1);

    reset = 1'b1; step(); step(); reset = 1'b0;
    chk("rst2_full", 32'(fullRob), 32'h0);

    // CDB to an unallocated tag is dropped.
    cdb(3'd5, 32'h77, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) alloc1(5'(i + 1), 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cdb(3'(i), 32'h10 + 32'(i), 1'b0, 32'h0);
    step();
    chk("t4_retire", 32'(commitROB), 32'h4);
    step();
    chk("t5_not_done_a", 32'(commitValid), 32'h0);
    step();
    chk("t5_not_done_b", 32'(commitValid), 32'h0);
    cdb(3'd5, 32'h99, 1'b0, 32'h0);
    step();
    chk("t5_cv",  32'(commitValid), 32'h1);
    chk("t5_rob", 32'(commitROB), 32'h5);
    chk("t5_res", commitResult, 32'h99);

    reset = 1'b1; step(); reset = 1'b0;

    // Wrap: 20 instructions through 8 slots.
    for (int k = 0; k < 20; k++) begin
      chk("wrap_dest", 32'(destROB), 32'(k % 8));
      alloc1(5'(k % 32), 1'b1, 1'b0, 32'h0);
      cdb(3'(k % 8), 32'(k * 3 + 1), 1'b0, 32'h0);
      step();
      chk("wrap_cv",  32'(commitValid), 32'h1);
      chk("wrap_rob", 32'(commitROB), 32'(k % 8));
      chk("wrap_res", commitResult, 32'(k * 3 + 1));
    end

    // Reset on the retire edge drops the pending pulse.
    t = destROB;
    alloc1(5'd3, 1'b1, 1'b0, 32'h0);
    cdb(t, 32'h5A, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    chk("rst_drop_cv", 32'(commitValid), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_drop_dest", 32'(destROB), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
